filter2d_seq_ctrl: RTL and testbench
====================================

// Module: filter2d_seq_ctrl
// PURPOSE
//  Frame sequencer for the filter2d datapath. On start, pushes the host coefficient bank into
//  filter2d over its h_write/h_idx/h_data port, then streams IMG_W*IMG_H pixels from an
//  external image RAM into i_strb/i_data at a programmable strobe spacing. It counts filter
//  output strobes and pulses done when the full frame has come out, or flags a timeout.
// PARAMETERS
//  IMG_W     256    pixels per line
//  IMG_H     256    lines per frame
//  NCOEF     9      coefficients loaded per frame (1..16)
//  AW        16     image RAM address width (2**AW >= IMG_W*IMG_H)
//  DRAIN_TO  4096   max cycles in DRAIN waiting for outstanding outputs
// PORTS
//  clk         in   1   clock
//  n_reset     in   1   synchronous active-low reset
//  start       in   1   begin a frame; sampled only in IDLE
//  gap         in   8   idle cycles between input strobes; sampled at start
//  busy        out  1   high from the cycle after an accepted start until done
//  done        out  1   one-cycle pulse at end of frame
//  err         out  1   sticky DRAIN timeout flag; cleared by next accepted start
//  coef_we     in   1   host coefficient write; ignored while busy
//  coef_idx    in   4   host coefficient index
//  coef_data   in   8   host coefficient value
//  mem_rd      out  1   image RAM read enable
//  mem_addr    out  AW  image RAM address, raster order
//  mem_rdata   in   8   image RAM data, valid the cycle after mem_rd
//  f_i_strb    out  1   pixel strobe to filter2d
//  f_i_data    out  8   pixel to filter2d; 0 when f_i_strb low
//  f_h_write   out  1   coefficient write to filter2d
//  f_h_idx     out  4   coefficient index to filter2d
//  f_h_data    out  8   coefficient value to filter2d
//  f_o_strb    in   1   output strobe from filter2d
//  out_cnt     out  AW+1  filter outputs counted this frame
// BEHAVIOUR
//  Reset (n_reset low at posedge): all outputs 0, FSM IDLE, counters 0. Coefficient bank is
//   not cleared. Reset mid-frame aborts it at once: no done, stream outputs low next cycle.
//  FSM: IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches gap, clears out_cnt/err, enters LOAD. coef_we writes bank[coef_idx].
//   start while busy is ignored; coef_we while busy is ignored.
//  LOAD: NCOEF cycles, f_h_write=1, f_h_idx=k, f_h_data=bank[k], k=0..NCOEF-1.
//  STREAM: per pixel p (0..IMG_W*IMG_H-1): cycle t mem_rd=1, mem_addr=p; cycle t+1
//   f_i_strb=1, f_i_data=mem_rdata; then gap cycles with f_i_strb=0. Strobe period = gap+2
//   cycles (gap=0 -> every 2nd cycle). mem_addr holds last value when mem_rd low. After
//   the final pixel strobe -> DRAIN.
//  f_o_strb counted in LOAD, STREAM and DRAIN; out_cnt saturates at IMG_W*IMG_H.
//  DRAIN: exits when out_cnt == IMG_W*IMG_H (may already hold on entry) or after DRAIN_TO
//   cycles (then err=1). A strobe arriving on the timeout cycle is counted and no err set.
//  DONE: done=1 for one cycle, busy=0 the same cycle; IDLE next cycle. start on the DONE
//   cycle is ignored.
//  Latency: start at cycle 0 -> first f_h_write at 1 -> first mem_rd at NCOEF+1 -> first
//   f_i_strb at NCOEF+2.
//  Widths: pixel counter AW+1 bits to hold IMG_W*IMG_H; gap counter 8 bits unsigned.
// STRUCTURE
//  filter2d_defs.vh: FSM state encodings (3-bit), DEF_NCOEF, coef width 8, idx width 4.
//  Sub-module filter2d_coef_bank: 16x8 register file, one sync write port (host), one
//   async read port (LOAD sequencer). Remainder (FSM, counters) in this module.
// TESTING
//  1 Reset: drive n_reset=0 two cycles -> every output 0, busy=0; RAM not read.
//  2 Coef load: write bank 0..8 = 1..9, start -> f_h_write high cycles 1..9, idx 0..8,
//    data 1..9; coef_we with data 0xFF during LOAD does not change a later frame's load.
//  3 Stream, IMG_W=IMG_H=4, gap=16, RAM=addr -> 16 strobes spaced 18 cycles, data 0..15,
//    mem_addr 0..15; stub filter echoing f_i_strb -> done one cycle after out_cnt=16.
//  4 gap=0 back-to-back: strobe every 2nd cycle; start held high through frame -> one
//    frame only, second start accepted only after DONE->IDLE.
//  5 Stub filter withholds last output -> err=1 and done after DRAIN_TO cycles, out_cnt=15.
//  6 n_reset low mid-STREAM -> f_i_strb/mem_rd 0 next cycle, no done; new start runs clean.

Source files
------------

// File: rtl/filter2d_seq_ctrl_pkg.sv
// Shared constants for the filter2d frame sequencer: FSM state codes,
// stream sub-phase codes and coefficient bank geometry.
package filter2d_seq_ctrl_pkg;

  localparam int COEF_W    = 8;
  localparam int IDX_W     = 4;
  localparam int NBANK     = 16;
  localparam int DEF_NCOEF = 9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] PH_READ = 2'd0;
  localparam logic [1:0] PH_STRB = 2'd1;
  localparam logic [1:0] PH_GAP  = 2'd2;

endpackage

// File: rtl/filter2d_seq_ctrl_coef_bank.sv
// Host coefficient bank: 16x8 registers, synchronous host write port,
// asynchronous read port for the LOAD sequencer. Contents survive reset.
module filter2d_seq_ctrl_coef_bank
  import filter2d_seq_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [COEF_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [COEF_W-1:0] o_rdata
);

  logic [COEF_W-1:0] r_bank [NBANK];

  always_ff @(posedge i_clk) begin
    if (i_we) r_bank[i_widx] <= i_wdata;
  end

  assign o_rdata = r_bank[i_ridx];

endmodule

// File: rtl/filter2d_seq_ctrl.sv
// Frame sequencer for filter2d: loads the coefficient bank, streams the image
// from RAM at a programmable strobe spacing, counts outputs, flags drain timeout.
module filter2d_seq_ctrl
  import filter2d_seq_ctrl_pkg::*;
#(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int NCOEF    = DEF_NCOEF,
  parameter int AW       = 16,
  parameter int DRAIN_TO = 4096
) (
  input  logic              i_clk,
  input  logic              i_n_reset,
  input  logic              i_start,
  input  logic [7:0]        i_gap,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  input  logic              i_coef_we,
  input  logic [IDX_W-1:0]  i_coef_idx,
  input  logic [COEF_W-1:0] i_coef_data,
  output logic              o_mem_rd,
  output logic [AW-1:0]     o_mem_addr,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_f_i_strb,
  output logic [7:0]        o_f_i_data,
  output logic              o_f_h_write,
  output logic [IDX_W-1:0]  o_f_h_idx,
  output logic [COEF_W-1:0] o_f_h_data,
  input  logic              i_f_o_strb,
  output logic [AW:0]       o_out_cnt
);

  localparam int NPIX_I    = IMG_W * IMG_H;
  localparam int NPIX_M1_I = NPIX_I - 1;
  localparam int TW        = $clog2(DRAIN_TO + 1);

  localparam logic [AW:0]      NPIX    = NPIX_I[AW:0];
  localparam logic [AW:0]      NPIX_M1 = NPIX_M1_I[AW:0];
  localparam logic [TW-1:0]    TO_LOAD = TW'(DRAIN_TO - 1);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(NCOEF - 1);

  logic [2:0]       r_state;
  logic [1:0]       r_phase;
  logic [IDX_W-1:0] r_k;
  logic [7:0]       r_gap;
  logic [7:0]       r_gap_cnt;
  logic [AW:0]      r_pix;
  logic [AW-1:0]    r_addr;
  logic [AW:0]      r_out_cnt;
  logic [TW-1:0]    r_to;
  logic             r_err;

  logic              w_idle;
  logic              w_load;
  logic              w_counting;
  logic              w_cnt_full;
  logic              w_last_pix;
  logic [AW:0]       w_pix_nxt;
  logic [COEF_W-1:0] w_bank_rdata;

  assign w_idle     = (r_state == S_IDLE);
  assign w_load     = (r_state == S_LOAD);
  assign w_counting = w_load || (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_cnt_full = (r_out_cnt == NPIX);
  assign w_last_pix = (r_pix == NPIX_M1);
  assign w_pix_nxt  = r_pix + 1'b1;

  filter2d_seq_ctrl_coef_bank u_bank (
    .i_clk   (i_clk),
    .i_we    (i_coef_we && w_idle),
    .i_widx  (i_coef_idx),
    .i_wdata (i_coef_data),
    .i_ridx  (r_k),
    .o_rdata (w_bank_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      r_state   <= S_IDLE;
      r_phase   <= PH_READ;
      r_k       <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_pix     <= '0;
      r_addr    <= '0;
      r_out_cnt <= '0;
      r_to      <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_counting && i_f_o_strb && !w_cnt_full) r_out_cnt <= r_out_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_LOAD;
            r_gap     <= i_gap;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
            r_k       <= '0;
          end
        end
        S_LOAD: begin
          if (r_k == K_LAST) begin
            r_state <= S_STREAM;
            r_phase <= PH_READ;
            r_pix   <= '0;
            r_addr  <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_STREAM: begin
          case (r_phase)
            PH_READ: r_phase <= PH_STRB;
            PH_STRB: begin
              if (w_last_pix) begin
                r_state <= S_DRAIN;
                r_to    <= TO_LOAD;
              end else if (r_gap == 8'd0) begin
                r_phase <= PH_READ;
                r_pix   <= w_pix_nxt;
                r_addr  <= w_pix_nxt[AW-1:0];
              end else begin
                r_phase   <= PH_GAP;
                r_gap_cnt <= r_gap - 8'd1;
              end
            end
            default: begin
              if (r_gap_cnt == 8'd0) begin
                r_phase <= PH_READ;
                r_pix   <= w_pix_nxt;
                r_addr  <= w_pix_nxt[AW-1:0];
              end else begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
              end
            end
          endcase
        end
        S_DRAIN: begin
          if (w_cnt_full) begin
            r_state <= S_DONE;
          end else if (r_to == '0) begin
            // a strobe landing on the timeout cycle that completes the frame is not an error
            r_state <= S_DONE;
            r_err   <= !(i_f_o_strb && (r_out_cnt == NPIX_M1));
          end else begin
            r_to <= r_to - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = w_counting;
  assign o_done      = (r_state == S_DONE);
  assign o_err       = r_err;
  assign o_mem_rd    = (r_state == S_STREAM) && (r_phase == PH_READ);
  assign o_mem_addr  = r_addr;
  assign o_f_i_strb  = (r_state == S_STREAM) && (r_phase == PH_STRB);
  assign o_f_i_data  = o_f_i_strb ? i_mem_rdata : 8'd0;
  assign o_f_h_write = w_load;
  assign o_f_h_idx   = w_load ? r_k : '0;
  assign o_f_h_data  = w_load ? w_bank_rdata : '0;
  assign o_out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_filter2d_seq_ctrl.sv
// Self-checking bench for filter2d_seq_ctrl: random frames against a timeline
// model derived from the frame rules, with a delaying/dropping stub filter.
module tb_filter2d_seq_ctrl;

  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int NCOEF    = 9;
  localparam int AW       = 4;
  localparam int DRAIN_TO = 40;
  localparam int NPIX     = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          start;
  logic [7:0]    gap;
  logic          busy, done, err;
  logic          coef_we;
  logic [3:0]    coef_idx;
  logic [7:0]    coef_data;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          f_i_strb;
  logic [7:0]    f_i_data;
  logic          f_h_write;
  logic [3:0]    f_h_idx;
  logic [7:0]    f_h_data;
  logic          f_o_strb;
  logic [AW:0]   out_cnt;

  always #5 clk = ~clk;

  filter2d_seq_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .NCOEF(NCOEF), .AW(AW), .DRAIN_TO(DRAIN_TO)
  ) dut (
    .i_clk(clk), .i_n_reset(n_reset), .i_start(start), .i_gap(gap),
    .o_busy(busy), .o_done(done), .o_err(err),
    .i_coef_we(coef_we), .i_coef_idx(coef_idx), .i_coef_data(coef_data),
    .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_f_i_strb(f_i_strb), .o_f_i_data(f_i_data),
    .o_f_h_write(f_h_write), .o_f_h_idx(f_h_idx), .o_f_h_data(f_h_data),
    .i_f_o_strb(f_o_strb), .o_out_cnt(out_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] m_bank [16];
  logic [7:0] ram [NPIX];

  // image RAM: one-cycle read latency
  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  // stub filter: echoes pixel strobes after echo_dly cycles, optionally dropping the last
  int         echo_dly  = 0;
  bit         drop_last = 1'b0;
  int         in_seen   = 0;
  logic [7:0] shreg     = '0;
  logic       echo_src;

  assign echo_src = f_i_strb && !(drop_last && in_seen == NPIX - 1);
  assign f_o_strb = (echo_dly == 0) ? echo_src : shreg[echo_dly-1];

  always @(posedge clk) begin
    if (start && !busy) in_seen <= 0;
    else if (f_i_strb)  in_seen <= in_seen + 1;
    shreg <= {shreg[6:0], echo_src};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write_coef(input int idx, input logic [7:0] data);
    @(negedge clk);
    coef_we = 1'b1; coef_idx = idx[3:0]; coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
    m_bank[idx] = data;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_mem_rd"}, mem_rd, 0);
    check_eq({tag, "_strb"}, f_i_strb, 0);
    check_eq({tag, "_idata"}, f_i_data, 0);
    check_eq({tag, "_hwrite"}, f_h_write, 0);
    check_eq({tag, "_cnt"}, out_cnt, 0);
  endtask

  // assert reset at this negedge, check one cycle later, then watch for a stray done
  task automatic abort_frame();
    n_reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    check_eq("abort_err", err, 0);
    n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", done, 0);
    end
  endtask

  task automatic run_frame(input int g, input int dly, input bit drop, input bit hold,
                           input int abort_at);
    int lastc, tdone, s, per, p;
    bit exp_rd, exp_st, exp_hw;
    for (int i = 0; i < NPIX; i++) ram[i] = 8'($urandom);
    echo_dly  = dly;
    drop_last = drop;
    per   = g + 2;
    lastc = NCOEF + 2 + (NPIX - 1) * per;
    tdone = drop ? lastc + 1 + DRAIN_TO : lastc + dly + 2;
    @(negedge clk);
    gap = 8'(g); start = 1'b1;
    for (int t = 1; t <= tdone + 1; t++) begin
      @(negedge clk);
      if (t == 1 && !hold) start = 1'b0;
      if (abort_at != 0 && t == abort_at) begin
        abort_frame();
        return;
      end
      exp_hw = (t >= 1) && (t <= NCOEF);
      check_eq("h_write", f_h_write, exp_hw);
      if (exp_hw) begin
        check_eq("h_idx", f_h_idx, t - 1);
        check_eq("h_data", f_h_data, m_bank[t-1]);
      end
      s = t - (NCOEF + 1);
      exp_rd = (s >= 0) && (s % per == 0) && (s / per < NPIX);
      check_eq("mem_rd", mem_rd, exp_rd);
      if (exp_rd) check_eq("mem_addr", mem_addr, s / per);
      exp_st = (s >= 1) && ((s - 1) % per == 0) && ((s - 1) / per < NPIX);
      check_eq("i_strb", f_i_strb, exp_st);
      p = exp_st ? (s - 1) / per : 0;
      check_eq("i_data", f_i_data, exp_st ? ram[p] : 8'd0);
      check_eq("busy", busy, t < tdone);
      check_eq("done", done, t == tdone);
      check_eq("err", err, drop && t >= tdone);
      if (t == 1) check_eq("cnt_clr", out_cnt, 0);
      if (t == tdone) check_eq("out_cnt", out_cnt, drop ? NPIX - 1 : NPIX);
      if (t == 3) begin
        coef_we = 1'b1; coef_idx = 4'($urandom_range(0, NCOEF - 1)); coef_data = 8'hFF;
      end
      if (t == 4) coef_we = 1'b0;
    end
    if (hold) begin
      @(negedge clk);
      check_eq("hold_restart_busy", busy, 1);
      abort_frame();
    end
  endtask

  initial begin
    n_reset = 1'b0; start = 1'b0; gap = '0;
    coef_we = 1'b0; coef_idx = '0; coef_data = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check_eq("reset_err", err, 0);
    check_eq("reset_addr", mem_addr, 0);
    n_reset = 1'b1;

    for (int i = 0; i < NCOEF; i++) write_coef(i, 8'(i + 1));
    run_frame(16, 0, 1'b0, 1'b0, 0);
    run_frame(0, 0, 1'b0, 1'b0, 0);

    for (int f = 0; f < 5; f++) begin
      write_coef($urandom_range(0, NCOEF - 1), 8'($urandom));
      write_coef($urandom_range(0, NCOEF - 1), 8'($urandom));
      run_frame($urandom_range(0, 5), $urandom_range(0, 5),
                ($urandom_range(0, 3) == 0), 1'b0, 0);
    end

    run_frame(2, 1, 1'b1, 1'b0, 0);
    run_frame(0, 0, 1'b0, 1'b1, 0);
    run_frame(3, 2, 1'b0, 1'b0, 40);
    run_frame(1, 3, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
